// File: rtl/inst_stream_encoder.sv
// -----------------------------------------------------------------------------
// inst_stream_encoder
//
// Builds RV32I instruction words from field-level requests and streams them
// into consecutive instruction-memory words. It is the inverse of the CPU's
// opcode decode. Loading stops after an ECALL word is written or the memory
// is full.
//
// Parameters
//   DEPTH   instruction-memory size in words (power of two, >= 2)
//   ADDR_W  word-address width
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse; (re)starts loading from address 0
//   req_valid/ready   request handshake
//   req_kind          0=R 1=I-arith 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR
//                     7=ECALL 8=LUI 9=AUIPC, anything else is illegal
//   req_rd/rs1/rs2    register fields
//   req_funct3        funct3 field
//   req_alt           selects funct7=0100000 (SUB/SRA/SRAI)
//   req_imm           signed immediate (LUI/AUIPC use bits 31:12)
//   imem_we/addr/wdata one-cycle memory write, issued the cycle after accept
//   count             words written since start
//   done              loading finished
//   full              count == DEPTH
//   error             sticky: illegal kind or out-of-range immediate seen
// -----------------------------------------------------------------------------
module inst_stream_encoder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              error
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    localparam logic [3:0] K_R      = 4'd0;
    localparam logic [3:0] K_IARITH = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_ECALL  = 4'd7;
    localparam logic [3:0] K_LUI    = 4'd8;
    localparam logic [3:0] K_AUIPC  = 4'd9;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when imm is representable as a signed value whose sign bit is msb.
    function automatic logic fits_signed(input logic [31:0] imm, input logic [4:0] msb);
        logic [31:0] hi;
        hi = 32'($signed(imm) >>> msb);
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

    // Returns {error, word} for one request.
    function automatic logic [32:0] encode_req(
        input logic [3:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic        alt,
        input logic [31:0] imm
    );
        logic [31:0] word;
        logic        err;
        logic [6:0]  f7;
        word = 32'h0000_0000;
        err  = 1'b0;
        f7   = alt ? 7'b0100000 : 7'b0000000;
        case (kind)
            K_R: begin
                word = {f7, rs2, rs1, f3, rd, OP_R};
            end
            K_IARITH: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    word = {f7, imm[4:0], rs1, f3, rd, OP_IARITH};
                    err  = (imm[31:5] != 27'd0);
                end else begin
                    word = {imm[11:0], rs1, f3, rd, OP_IARITH};
                    err  = !fits_signed(imm, 5'd11);
                end
            end
            K_LOAD: begin
                word = {imm[11:0], rs1, f3, rd, OP_LOAD};
                err  = !fits_signed(imm, 5'd11);
            end
            K_STORE: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
                err  = !fits_signed(imm, 5'd11);
            end
            K_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
                err  = !fits_signed(imm, 5'd12) || imm[0];
            end
            K_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                err  = !fits_signed(imm, 5'd20) || imm[0];
            end
            K_JALR: begin
                word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                err  = !fits_signed(imm, 5'd11);
            end
            K_ECALL: begin
                word = ECALL_WORD;
            end
            K_LUI: begin
                word = {imm[31:12], rd, OP_LUI};
            end
            K_AUIPC: begin
                word = {imm[31:12], rd, OP_AUIPC};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        return {err, word};
    endfunction

    state_t            state_r;
    logic              ready_r;
    logic              stop_pending_r;
    logic [ADDR_W:0]   wptr_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [ADDR_W:0]   count_r;
    logic              done_r;
    logic              full_r;
    logic              error_r;

    logic [32:0]       enc_s;
    logic              accept_s;
    logic [ADDR_W:0]   wptr_next_s;
    logic [ADDR_W:0]   count_next_s;
    logic              last_s;

    assign enc_s        = encode_req(req_kind, req_rd, req_rs1, req_rs2,
                                     req_funct3, req_alt, req_imm);
    assign accept_s     = req_valid && ready_r;
    assign wptr_next_s  = wptr_r + ONE_C;
    assign count_next_s = count_r + ONE_C;
    // The accepted word is the final one: ECALL, or it fills the memory.
    assign last_s       = (req_kind == K_ECALL) || (wptr_next_s == DEPTH_C);

    // Control FSM, write pipeline stage and status registers.
    // wptr_r runs ahead of count_r by one while a write is in flight so that
    // back-to-back requests get consecutive addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            ready_r        <= 1'b0;
            stop_pending_r <= 1'b0;
            wptr_r         <= '0;
            we_r           <= 1'b0;
            addr_r         <= '0;
            wdata_r        <= 32'h0000_0000;
            count_r        <= '0;
            done_r         <= 1'b0;
            full_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r        <= ST_RUN;
                        ready_r        <= 1'b1;
                        stop_pending_r <= 1'b0;
                        wptr_r         <= '0;
                        count_r        <= '0;
                        done_r         <= 1'b0;
                        full_r         <= 1'b0;
                        error_r        <= 1'b0;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (enc_s[32]) begin
                            error_r <= 1'b1;
                        end else begin
                            we_r    <= 1'b1;
                            addr_r  <= wptr_r[ADDR_W-1:0];
                            wdata_r <= enc_s[31:0];
                            wptr_r  <= wptr_next_s;
                            if (last_s) begin
                                stop_pending_r <= 1'b1;
                                ready_r        <= 1'b0;
                            end
                        end
                    end
                    if (we_r) begin
                        count_r <= count_next_s;
                        full_r  <= (count_next_s == DEPTH_C);
                        // Nothing is accepted after the final word, so a
                        // write with stop pending is always the last one.
                        if (stop_pending_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            ready_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_r;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign count      = count_r;
    assign done       = done_r;
    assign full       = full_r;
    assign error      = error_r;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_stream_encoder
//
// Directed bench for inst_stream_encoder. dut_a uses the default depth and
// covers encoding, errors, ECALL and restart; dut_b uses DEPTH=4 and covers
// the memory-full stop and reset during a pending write. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inst_stream_encoder;

    logic        clk;
    logic        reset, reset_b;
    logic        start, start_b;
    logic        req_valid, req_valid_b;
    logic        req_ready, req_ready_b;
    logic [3:0]  req_kind;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [31:0] req_imm;

    logic        imem_we, imem_we_b;
    logic [9:0]  imem_addr;
    logic [1:0]  imem_addr_b;
    logic [31:0] imem_wdata, imem_wdata_b;
    logic [10:0] count;
    logic [2:0]  count_b;
    logic        done, done_b, full, full_b, error, error_b;

    int checks = 0;
    int errors = 0;

    inst_stream_encoder dut_a (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_alt(req_alt), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .full(full), .error(error)
    );

    inst_stream_encoder #(.DEPTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_alt(req_alt), .req_imm(req_imm),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .count(count_b), .done(done_b), .full(full_b), .error(error_b)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic set_req(input logic [3:0] kind, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic alt,
                           input logic [31:0] imm);
        req_kind   = kind;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_alt    = alt;
        req_imm    = imm;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, imem_we, imem_addr, imem_wdata, count, done, full, error} !== 62'd0) begin
            errors++;
            $display("FAIL reset_a got rdy=%b we=%b addr=%0d wd=%h cnt=%0d d=%b f=%b e=%b want all 0",
                     req_ready, imem_we, imem_addr, imem_wdata, count, done, full, error);
        end
        checks++;
        if ({req_ready_b, imem_we_b, imem_addr_b, imem_wdata_b, count_b, done_b, full_b, error_b} !== 42'd0) begin
            errors++;
            $display("FAIL reset_b got rdy=%b we=%b cnt=%0d want all 0", req_ready_b, imem_we_b, count_b);
        end
        reset   = 1'b1;
        reset_b = 1'b1;
        req_valid = 1'b1;
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept got rdy=%b we=%b want 0 0", req_ready, imem_we);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || count !== 11'd0) begin
            errors++;
            $display("FAIL start got rdy=%b cnt=%0d want 1 0", req_ready, count);
        end
    endtask

    task automatic test_addi();
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h0050_0093 || count !== 11'd0) begin
            errors++;
            $display("FAIL addi got we=%b addr=%0d wd=%h cnt=%0d want 1 0 00500093 0",
                     imem_we, imem_addr, imem_wdata, count);
        end
        @(negedge clk);
        checks++;
        if (count !== 11'd1 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL addi_count got cnt=%0d we=%b want 1 0", count, imem_we);
        end
    endtask

    task automatic test_back_to_back();
        set_req(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wdata !== 32'h0020_81B3) begin
            errors++;
            $display("FAIL add got we=%b addr=%0d wd=%h want 1 1 002081b3", imem_we, imem_addr, imem_wdata);
        end
        set_req(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd2 || imem_wdata !== 32'h4020_81B3) begin
            errors++;
            $display("FAIL sub got we=%b addr=%0d wd=%h want 1 2 402081b3", imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        checks++;
        if (count !== 11'd3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", count);
        end
    endtask

    task automatic test_formats();
        logic [31:0] exp_word [6];
        exp_word[0] = 32'h0020_A423;  // sw   x2,8(x1)
        exp_word[1] = 32'hFE20_8EE3;  // beq  x1,x2,-4
        exp_word[2] = 32'h0080_00EF;  // jal  x1,8
        exp_word[3] = 32'h1234_52B7;  // lui  x5,0x12345
        exp_word[4] = 32'h01F0_9093;  // slli x1,x1,31
        exp_word[5] = 32'h4030_D093;  // srai x1,x1,3
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_req(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
                1: set_req(4'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFC);
                2: set_req(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8);
                3: set_req(4'd8, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000);
                4: set_req(4'd1, 5'd1, 5'd1, 5'd0, 3'b001, 1'b0, 32'd31);
                default: set_req(4'd1, 5'd1, 5'd1, 5'd0, 3'b101, 1'b1, 32'd3);
            endcase
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 10'(i + 3) || imem_wdata !== exp_word[i]) begin
                errors++;
                $display("FAIL format%0d got we=%b addr=%0d wd=%h want 1 %0d %h",
                         i, imem_we, imem_addr, imem_wdata, i + 3, exp_word[i]);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 11'd9 || error !== 1'b0) begin
            errors++;
            $display("FAIL formats_count got cnt=%0d err=%b want 9 0", count, error);
        end
    endtask

    task automatic test_errors();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_req(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);     // odd branch
                1: set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);  // addi too big
                2: set_req(4'd12, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);    // illegal kind
                default: set_req(4'd1, 5'd1, 5'd1, 5'd0, 3'b001, 1'b0, 32'd32); // shamt 32
            endcase
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b0 || error !== 1'b1 || count !== 11'd9) begin
                errors++;
                $display("FAIL err%0d got we=%b err=%b cnt=%0d want 0 1 9", i, imem_we, error, count);
            end
        end
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F800);  // addi x1,x0,-2048
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd9 || imem_wdata !== 32'h8000_0093) begin
            errors++;
            $display("FAIL after_err got we=%b addr=%0d wd=%h want 1 9 80000093", imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        checks++;
        if (count !== 11'd10 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got cnt=%0d err=%b want 10 1", count, error);
        end
    endtask

    task automatic test_ecall();
        set_req(4'd7, 5'd5, 5'd5, 5'd5, 3'b111, 1'b1, 32'hFFFF_FFFF);
        req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 10'd10 || imem_wdata !== 32'h0000_0073) begin
            errors++;
            $display("FAIL ecall got rdy=%b we=%b addr=%0d wd=%h want 0 1 10 00000073",
                     req_ready, imem_we, imem_addr, imem_wdata);
        end
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || imem_we !== 1'b0 || count !== 11'd11 || full !== 1'b0) begin
            errors++;
            $display("FAIL ecall_done got d=%b we=%b cnt=%0d f=%b want 1 0 11 0", done, imem_we, count, full);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || count !== 11'd11 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ecall_ignore got we=%b cnt=%0d rdy=%b want 0 11 0", imem_we, count, req_ready);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || count !== 11'd0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL restart got rdy=%b cnt=%0d d=%b e=%b want 1 0 0 0", req_ready, count, done, error);
        end
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd0) begin
            errors++;
            $display("FAIL restart_addr got we=%b addr=%0d want 1 0", imem_we, imem_addr);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        req_valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i + 1));
            exp = {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13};
            @(negedge clk);
            checks++;
            if (imem_we_b !== 1'b1 || imem_addr_b !== 2'(i) || imem_wdata_b !== exp) begin
                errors++;
                $display("FAIL fill%0d got we=%b addr=%0d wd=%h want 1 %0d %h",
                         i, imem_we_b, imem_addr_b, imem_wdata_b, i, exp);
            end
        end
        checks++;
        if (req_ready_b !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready got %b want 0", req_ready_b);
        end
        @(negedge clk);
        req_valid_b = 1'b0;
        checks++;
        if (done_b !== 1'b1 || full_b !== 1'b1 || error_b !== 1'b0 || count_b !== 3'd4 || imem_we_b !== 1'b0) begin
            errors++;
            $display("FAIL fill_done got d=%b f=%b e=%b cnt=%0d we=%b want 1 1 0 4 0",
                     done_b, full_b, error_b, count_b, imem_we_b);
        end
    endtask

    task automatic test_reset_mid();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        req_valid_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        checks++;
        if (imem_we_b !== 1'b1) begin
            errors++;
            $display("FAIL pending_write got we=%b want 1", imem_we_b);
        end
        reset_b = 1'b0;
        #1;
        checks++;
        if ({req_ready_b, imem_we_b, imem_addr_b, imem_wdata_b, count_b, done_b, full_b, error_b} !== 42'd0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b we=%b addr=%0d wd=%h cnt=%0d d=%b f=%b e=%b want all 0",
                     req_ready_b, imem_we_b, imem_addr_b, imem_wdata_b, count_b, done_b, full_b, error_b);
        end
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_we_b !== 1'b0 || count_b !== 3'd0 || req_ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after got we=%b cnt=%0d rdy=%b want 0 0 0", imem_we_b, count_b, req_ready_b);
        end
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b0;
        reset_b     = 1'b0;
        start       = 1'b0;
        start_b     = 1'b0;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        test_reset();
        test_start();
        test_addi();
        test_back_to_back();
        test_formats();
        test_errors();
        test_ecall();
        test_restart();
        test_fill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_stream_encoder.md
# inst_stream_encoder

Sequential RV32I instruction encoder and instruction-memory loader; the inverse of the CPU's opcode decode. It accepts field-level instruction requests over a valid/ready handshake and assembles the 32-bit RV32I word. It range-checks immediates and streams each word into consecutive instruction-memory locations. Test benches and the boot loader use it to build programs. Loading finishes when an ECALL (halt) word is written or the memory is full.

## Interface
Parameters:
- DEPTH, 1024: instruction-memory size in words; a power of two, at least 2.
- ADDR_W, $clog2(DEPTH): word-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse. Clears the pointer and flags and enters RUN; ignored while in RUN.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_kind  input  4  0=R, 1=I-arith, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=ECALL, 8=LUI, 9=AUIPC; 10-15 illegal.
- req_rd, req_rs1, req_rs2  input  5 each  register fields.
- req_funct3  input  3  funct3 field.
- req_alt  input  1  selects funct7=0100000 (SUB/SRA/SRAI); otherwise 0000000.
- req_imm  input  32  signed immediate; LUI/AUIPC use req_imm[31:12].
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since start.
- done  output  1  loading finished (ECALL written or memory full).
- full  output  1  count == DEPTH.
- error  output  1  sticky; set by an illegal kind or an out-of-range immediate.

## Operation
- States:
  - IDLE (after reset): start moves to RUN.
  - RUN: encodes requests. Moves to DONE on the cycle its write completes if the written word is ECALL or count reaches DEPTH.
  - DONE: start moves to RUN.
- req_ready = (state==RUN) && !stop_pending. stop_pending is set in the acceptance cycle of an ECALL request, or when the accepted request's write will make count==DEPTH.
- Opcodes:
  - R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111, ECALL 1110011, LUI 0110111, AUIPC 0010111.
- R-type: {f7, rs2, rs1, f3, rd, op}.
- I-arith:
  - f3=001/101 (shifts): imm field is {f7, imm[4:0]}; imm must be in 0..31.
  - Other f3 values: imm[11:0].
- LOAD: imm[11:0].
- JALR: imm[11:0], with f3 forced to 000.
- I-format range: imm must lie in -2048..2047.
- STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}; range -2048..2047.
- BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; range -4096..4094; imm[0] must be 0.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; range ±1 MiB; imm[0] must be 0.
- LUI/AUIPC: {imm[31:12], rd, op}.
- ECALL: constant 0x00000073; all fields ignored.
- Fields not used by a format are ignored.
- Errored request: consumed (handshake completes), no write, error set, pointer unchanged.

## Timing
- Reset values:
  - state=IDLE.
  - req_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - count=0, done=0, full=0, error=0.
- Latency: a request accepted in cycle N produces imem_we=1 in cycle N+1. In that cycle imem_addr = count before the increment; count increments at the end of N+1.
- Throughput is one word per cycle, with back-to-back acceptance.
- The write pointer cannot wrap. It stops at DEPTH and full asserts. A DONE reached by filling memory without an ECALL does not set error.
- done asserts the cycle after the final write strobe.
- start pulse:
  - Takes effect in IDLE or DONE.
  - Clears count, done, full and error.
  - req_ready rises the next cycle.
- Reset asserted mid-operation: any pending write is dropped and all outputs return to reset values immediately.
- req_valid while not ready: held, not consumed. Field inputs must stay stable until accepted.

## Test plan
- start; addi x1,x0,5 (kind1, rd1, rs1 0, f3 0, imm 5) → cycle+1: imem_we=1, addr 0, wdata 0x00500093; count=1.
- Back-to-back: add x3,x1,x2 then same with alt=1 → 0x002081B3 @0, 0x402081B3 @1 on consecutive cycles.
- sw x2,8(x1) → 0x0020A423. beq x1,x2,-4 → 0xFE208EE3. jal x1,8 → 0x008000EF.
- Errors: branch imm=3 → no write, error=1, count unchanged. addi imm=4096 → no write, error=1. A following valid request still writes at the unchanged address.
- ECALL → wdata 0x00000073; req_ready drops in the cycle after acceptance; done=1 after the write; further req_valid is ignored.
- DEPTH=4 fill: 4 addi writes → full=1, done=1, error=0. Reset asserted while a write is pending → no imem_we and all outputs return to zero.
